a2d_arbiter: RTL and testbench

- Shares the single round-robin A2D converter interface (strt_cnv/chnnl/cnv_cmplt/A2D_res) between two requesters.
- Requester M is the motion controller's IR sampling and has high priority. Requester A is the auxiliary/diagnostic sampler (battery, spare channels) and has low priority.
- Sits in the digital core between the requesters and the A2D interface block.
- Provides bounded starvation for A, a conversion watchdog, and a minimum recovery gap between conversions.

---
 rtl/a2d_arbiter.sv | 122 ++++++++++++
 tb/tb_a2d_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/a2d_arbiter.sv
// Two-requester arbiter in front of the shared A2D interface: M has priority,
// A gets forced through after STARVE_MAX M grants, plus a watchdog and a post-conversion gap.
module a2d_arbiter #(
  parameter int GAP_CYC    = 4,
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_strt,
  input  logic [2:0]  m_chnnl,
  output logic        m_busy,
  output logic        m_cmplt,
  input  logic        a_strt,
  input  logic [2:0]  a_chnnl,
  output logic        a_busy,
  output logic        a_cmplt,
  output logic [11:0] res,
  output logic        err,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res
);

  localparam int TMAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, CONV_M, CONV_A, GAP} state_t;

  state_t          state, state_nxt;
  logic            m_pend, a_pend;
  logic [2:0]      m_ch, a_ch;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmr;
  logic            grant_m, grant_a, done, tout, fin, in_conv;

  assign m_busy  = m_pend;
  assign a_busy  = a_pend;
  assign in_conv = (state == CONV_M) || (state == CONV_A);
  assign fin     = done || tout;

  always_comb begin
    state_nxt = state;
    grant_m   = 1'b0;
    grant_a   = 1'b0;
    done      = 1'b0;
    tout      = 1'b0;
    case (state)
      IDLE: begin
        if (a_pend && (!m_pend || starve_cnt == SW'(STARVE_MAX))) begin
          grant_a   = 1'b1;
          state_nxt = CONV_A;
        end else if (m_pend) begin
          grant_m   = 1'b1;
          state_nxt = CONV_M;
        end
      end
      CONV_M, CONV_A: begin
        // strt_cnv is high only in the first conversion cycle; a cnv_cmplt there is stale
        if (!strt_cnv && cnv_cmplt) done = 1'b1;
        else if (tmr == TW'(TIMEOUT - 1)) tout = 1'b1;
        if (done || tout) state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (tmr == TW'(GAP_CYC - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m_pend     <= 1'b0;
      a_pend     <= 1'b0;
      m_ch       <= '0;
      a_ch       <= '0;
      starve_cnt <= '0;
      tmr        <= '0;
      strt_cnv   <= 1'b0;
      chnnl      <= '0;
      m_cmplt    <= 1'b0;
      a_cmplt    <= 1'b0;
      err        <= 1'b0;
      res        <= '0;
    end else begin
      state    <= state_nxt;
      strt_cnv <= grant_m || grant_a;
      m_cmplt  <= fin && (state == CONV_M);
      a_cmplt  <= fin && (state == CONV_A);
      err      <= tout;
      if (done) res <= A2D_res;
      if (grant_m) chnnl <= m_ch;
      if (grant_a) chnnl <= a_ch;

      // one timer serves both the conversion watchdog and the gap count
      if (grant_m || grant_a || fin) tmr <= '0;
      else if (in_conv || state == GAP) tmr <= tmr + TW'(1);

      if (grant_a) starve_cnt <= '0;
      else if (grant_m) begin
        if (!a_pend) starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
      end

      if (fin && state == CONV_M) m_pend <= 1'b0;
      else if (m_strt && !m_pend) begin
        m_pend <= 1'b1;
        m_ch   <= m_chnnl;
      end

      if (fin && state == CONV_A) a_pend <= 1'b0;
      else if (a_strt && !a_pend) begin
        a_pend <= 1'b1;
        a_ch   <= a_chnnl;
      end
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Bench for a2d_arbiter: transaction/timestamp reference model plus directed and random phases.
module tb_a2d_arbiter;
  localparam int GAP_CYC = 4, STARVE_MAX = 8, TIMEOUT = 4096;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m_strt = 0, a_strt = 0, cnv_cmplt = 0;
  logic [2:0]  m_chnnl = 0, a_chnnl = 0;
  logic [11:0] A2D_res = 0;
  logic        m_busy, m_cmplt, a_busy, a_cmplt, err, strt_cnv;
  logic [11:0] res;
  logic [2:0]  chnnl;

  always #10 clk = ~clk;

  a2d_arbiter #(.GAP_CYC(GAP_CYC), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_strt(m_strt), .m_chnnl(m_chnnl), .m_busy(m_busy), .m_cmplt(m_cmplt),
    .a_strt(a_strt), .a_chnnl(a_chnnl), .a_busy(a_busy), .a_cmplt(a_cmplt),
    .res(res), .err(err), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // reference model: who owns the converter, when it started, when the next grant may happen
  bit          mp, ap;
  logic [2:0]  mch, ach;
  int          starve, owner, cstart, free_at, cyc;
  bit          e_strt, e_mc, e_ac, e_err;
  logic [2:0]  e_ch;
  logic [11:0] e_res;

  // stimulus for the next cycle, plus DUT event counters
  bit          g_ms, g_as, g_cc;
  logic [2:0]  g_mc, g_ac;
  logic [11:0] g_res;
  int          n_strt, n_err, n_mc, n_ac;
  logic [2:0]  strt_ch[$];

  task automatic model_reset();
    mp = 0; ap = 0; mch = 0; ach = 0; starve = 0; owner = 0; cstart = 0;
    free_at = 0; cyc = 0; e_strt = 0; e_mc = 0; e_ac = 0; e_err = 0; e_ch = 0; e_res = 0;
  endtask

  task automatic model_step();
    bit nmp = mp, nap = ap, fin_ok, abort;
    logic [2:0] nmch = mch, nach = ach;
    e_strt = 0; e_mc = 0; e_ac = 0; e_err = 0;
    if (m_strt && !mp) begin nmp = 1; nmch = m_chnnl; end
    if (a_strt && !ap) begin nap = 1; nach = a_chnnl; end
    if (owner != 0) begin
      fin_ok = (cyc > cstart) && cnv_cmplt;
      abort  = !fin_ok && (cyc - cstart + 1 == TIMEOUT);
      if (fin_ok || abort) begin
        if (fin_ok) e_res = A2D_res;
        e_err = abort;
        if (owner == 1) begin e_mc = 1; nmp = 0; end
        else begin e_ac = 1; nap = 0; end
        owner = 0;
        free_at = cyc + 1 + GAP_CYC;
      end
    end else if (cyc >= free_at && (mp || ap)) begin
      if (ap && (!mp || starve == STARVE_MAX)) begin
        owner = 2; e_ch = ach; starve = 0;
      end else begin
        owner = 1; e_ch = mch;
        starve = ap ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
      end
      e_strt = 1; cstart = cyc + 1;
    end
    mp = nmp; ap = nap; mch = nmch; ach = nach;
    cyc++;
  endtask

  task automatic clr_counts();
    n_strt = 0; n_err = 0; n_mc = 0; n_ac = 0; strt_ch.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
    m_strt = g_ms; m_chnnl = g_mc; a_strt = g_as; a_chnnl = g_ac;
    cnv_cmplt = g_cc; A2D_res = g_res;
    @(negedge clk);
    chk("outs", {strt_cnv, m_cmplt, a_cmplt, err, m_busy, a_busy, chnnl, res},
                {e_strt, e_mc, e_ac, e_err, mp, ap, e_ch, e_res});
    if (strt_cnv) begin n_strt++; strt_ch.push_back(chnnl); end
    if (err) n_err++;
    if (m_cmplt) n_mc++;
    if (a_cmplt) n_ac++;
    model_step();
    g_ms = 0; g_as = 0; g_cc = 0; g_res = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 0; m_strt = 0; a_strt = 0; cnv_cmplt = 0;
    @(negedge clk);
    chk("reset", {strt_cnv, m_cmplt, a_cmplt, err, m_busy, a_busy, chnnl, res}, 0);
    @(posedge clk); #1 rst_n = 1;
    model_reset(); clr_counts();
    g_ms = 0; g_as = 0; g_cc = 0; g_res = 0; g_mc = 0; g_ac = 0;
  endtask

  // converter answers a few cycles after each start; stray and stale pulses elsewhere
  task automatic auto_resp(input int lat);
    if (owner != 0 && cyc == cstart + lat) begin g_cc = 1; g_res = 12'($urandom); end
  endtask

  int mb;
  initial begin
    // single M with stale pulse, duplicate request and idle pulse
    reset_dut();
    g_ms = 1; g_mc = 3; step();
    for (int i = 0; i < 40; i++) begin
      if (owner == 1 && cyc == cstart) begin g_cc = 1; g_res = 12'hFFF; end
      if (owner == 1 && cyc == cstart + 5) begin g_ms = 1; g_mc = 7; end
      if (owner == 1 && cyc == cstart + 20) begin g_cc = 1; g_res = 12'hA5C; end
      if (i > 32) begin g_cc = 1; g_res = 12'h111; end
      step();
    end
    chk("single_res", res, 12'hA5C);
    chk("single_starts", n_strt, 1);
    chk("single_mcmplt", n_mc, 1);
    chk("single_acmplt", n_ac, 0);
    chk("single_err", n_err, 0);
    if (strt_ch.size() > 0) chk("single_ch", strt_ch[0], 3);

    // simultaneous requests: M first, A after the gap
    reset_dut();
    g_ms = 1; g_mc = 1; g_as = 1; g_ac = 6; step();
    for (int i = 0; i < 60; i++) begin auto_resp(3); step(); end
    chk("simul_starts", n_strt, 2);
    if (strt_ch.size() >= 2) begin
      chk("simul_first", strt_ch[0], 1);
      chk("simul_second", strt_ch[1], 6);
    end
    chk("simul_acmplt", n_ac, 1);

    // starvation: A pending while M keeps re-requesting
    reset_dut();
    g_ms = 1; g_mc = 1; g_as = 1; g_ac = 6; step();
    for (int i = 0; i < 300; i++) begin
      if (!mp && !e_mc) begin g_ms = 1; g_mc = 1; end
      auto_resp(2);
      step();
    end
    mb = 0;
    foreach (strt_ch[i]) begin
      if (strt_ch[i] == 3'd6) break;
      mb++;
    end
    chk("starve_m_grants", mb, STARVE_MAX);

    // timeout on A after a normal M conversion
    reset_dut();
    g_ms = 1; g_mc = 2; step();
    for (int i = 0; i < 4300; i++) begin
      if (owner == 1 && cyc == cstart + 2) begin g_cc = 1; g_res = 12'h3C3; end
      if (cyc == 12) begin g_as = 1; g_ac = 5; end
      step();
    end
    chk("tout_err", n_err, 1);
    chk("tout_acmplt", n_ac, 1);
    chk("tout_res", res, 12'h3C3);

    // reset in the middle of an M conversion
    reset_dut();
    g_ms = 1; g_mc = 4; step();
    for (int i = 0; i < 10; i++) step();
    chk("rst_owner_busy", m_busy, 1'b1);
    @(posedge clk); #1 rst_n = 0;
    #2 chk("rst_async", {strt_cnv, m_cmplt, a_cmplt, err, m_busy, a_busy, chnnl, res}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset(); clr_counts();
    for (int i = 0; i < 10; i++) begin g_cc = 1; g_res = 12'h777; step(); end
    chk("rst_no_cmplt", n_mc, 0);

    // random traffic
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      g_ms = ($urandom_range(0, 7) == 0) && !e_mc; g_mc = 3'($urandom);
      g_as = ($urandom_range(0, 7) == 0) && !e_ac; g_ac = 3'($urandom);
      if (owner != 0 && cyc == cstart) g_cc = ($urandom_range(0, 3) == 0);
      else if (owner != 0) g_cc = ($urandom_range(0, 5) == 0);
      else g_cc = ($urandom_range(0, 9) == 0);
      g_res = 12'($urandom);
      step();
    end
    chk("rand_activity", (n_mc > 0) && (n_ac > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
